// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM state encodings and sizing helpers for the arithmetic datapath
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/div_control_unit.sv
// rtl/div_control_unit.sv - per-step add/subtract, quotient bit and correction decode
module div_control_unit
  import arith_pkg::*;
(
  input  state_t i_state,
  input  logic   i_p_sign,
  input  logic   i_p_next_sign,
  output logic   o_add_d,
  output logic   o_sub_d,
  output logic   o_q_bit,
  output logic   o_corr_en
);

  // Kept as separate continuous assigns so the q-bit path, which depends on
  // the adder result, does not form a false loop with the add/sub decode.
  assign o_add_d   = (i_state == ITER) &&  i_p_sign;
  assign o_sub_d   = (i_state == ITER) && !i_p_sign;
  assign o_corr_en = (i_state == FIX)  &&  i_p_sign;
  assign o_q_bit   = ~i_p_next_sign;

endmodule

// File: rtl/gen_register.sv
// rtl/gen_register.sv - generic enabled register, synchronous active-high clear
module gen_register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - radix-2 non-restoring signed divider, one quotient bit per cycle
module seq_signed_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int              CW        = clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH:0]     r_p;
  logic [WIDTH-1:0]   r_qm;
  logic [WIDTH-1:0]   r_d;
  logic [2:0]         r_flags;   // {dividend sign, divisor sign, overflow case}
  logic [2*WIDTH+1:0] r_result;  // {quotient, remainder, div_by_zero, overflow}

  state_t             w_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_div0;
  logic               w_load;
  logic               w_iter;
  logic               w_add_d;
  logic               w_sub_d;
  logic               w_q_bit;
  logic               w_corr_en;
  logic [WIDTH:0]     w_d_ext;
  logic [WIDTH:0]     w_p_base;
  logic [WIDTH:0]     w_p_next;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_result_en;
  logic [2*WIDTH+1:0] w_result_d;

  assign w_state  = state_t'(r_state);
  assign w_accept = ((w_state == IDLE) || (w_state == DONE)) && start;
  assign w_div0   = (divisor_in == '0);
  assign w_load   = w_accept && !w_div0;
  assign w_iter   = (w_state == ITER);

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      IDLE, DONE: begin
        if (start) w_state_nxt = w_div0 ? DONE : ITER;
        else       w_state_nxt = IDLE;
      end
      ITER:    if (r_count == LAST_STEP) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  div_control_unit u_ctrl (
    .i_state       (w_state),
    .i_p_sign      (r_p[WIDTH]),
    .i_p_next_sign (w_p_next[WIDTH]),
    .o_add_d       (w_add_d),
    .o_sub_d       (w_sub_d),
    .o_q_bit       (w_q_bit),
    .o_corr_en     (w_corr_en)
  );

  // Magnitudes fit WIDTH unsigned bits, including |-2^(WIDTH-1)|.
  assign w_mag_a  = dividend_in[WIDTH-1] ? -dividend_in : dividend_in;
  assign w_mag_b  = divisor_in[WIDTH-1]  ? -divisor_in  : divisor_in;
  assign w_d_ext  = {1'b0, r_d};
  assign w_p_base = w_iter ? {r_p[WIDTH-1:0], r_qm[WIDTH-1]} : r_p;
  assign w_p_next = (w_add_d || w_corr_en) ? (w_p_base + w_d_ext) :
                    w_sub_d                ? (w_p_base - w_d_ext) : w_p_base;

  assign w_quot = (r_flags[2] ^ r_flags[1]) ? -r_qm : r_qm;
  assign w_rem  = r_flags[2] ? -w_p_next[WIDTH-1:0] : w_p_next[WIDTH-1:0];

  assign w_result_en = (w_state == FIX) || (w_accept && w_div0);

  always_comb begin
    w_result_d = {{WIDTH{1'b1}}, dividend_in, 1'b1, 1'b0};
    if (w_state == FIX) w_result_d = {w_quot, w_rem, 1'b0, r_flags[0]};
  end

  gen_register #(.W(2)) u_state_reg (
    .clk(clk), .rst(rst), .en(1'b1), .d(w_state_nxt), .q(r_state)
  );

  gen_register #(.W(CW)) u_count_reg (
    .clk(clk), .rst(rst), .en(w_load || w_iter),
    .d(w_load ? '0 : r_count + 1'b1), .q(r_count)
  );

  gen_register #(.W(WIDTH+1)) u_p_reg (
    .clk(clk), .rst(rst), .en(w_load || w_iter),
    .d(w_load ? '0 : w_p_next), .q(r_p)
  );

  gen_register #(.W(WIDTH)) u_qm_reg (
    .clk(clk), .rst(rst), .en(w_load || w_iter),
    .d(w_load ? w_mag_a : {r_qm[WIDTH-2:0], w_q_bit}), .q(r_qm)
  );

  gen_register #(.W(WIDTH)) u_d_reg (
    .clk(clk), .rst(rst), .en(w_load), .d(w_mag_b), .q(r_d)
  );

  gen_register #(.W(3)) u_flags_reg (
    .clk(clk), .rst(rst), .en(w_load),
    .d({dividend_in[WIDTH-1], divisor_in[WIDTH-1],
        (dividend_in == MOST_NEG) && (divisor_in == '1)}),
    .q(r_flags)
  );

  gen_register #(.W(2*WIDTH+2)) u_result_reg (
    .clk(clk), .rst(rst), .en(w_result_en), .d(w_result_d), .q(r_result)
  );

  assign busy          = (w_state == ITER) || (w_state == FIX);
  assign done          = (w_state == DONE);
  assign quotient_out  = r_result[2*WIDTH+1 -: WIDTH];
  assign remainder_out = r_result[WIDTH+1 -: WIDTH];
  assign div_by_zero   = r_result[1];
  assign overflow      = r_result[0];

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - scoreboard bench for seq_signed_divider
module tb_seq_signed_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend_in;
  logic [W-1:0] divisor_in;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient_out;
  logic [W-1:0] remainder_out;
  logic         div_by_zero;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .dividend_in   (dividend_in),
    .divisor_in    (divisor_in),
    .busy          (busy),
    .done          (done),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out),
    .div_by_zero   (div_by_zero),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // C-style truncating division with the defined corner results.
  function automatic res_t model(input int a, input int b);
    res_t e;
    if (b == 0) begin
      e.q = '1; e.r = W'(a); e.dbz = 1'b1; e.ovf = 1'b0;
    end else if (a == -(1 << (W-1)) && b == -1) begin
      e.q = W'(a); e.r = '0; e.dbz = 1'b0; e.ovf = 1'b1;
    end else begin
      e.q = W'(a / b); e.r = W'(a % b); e.dbz = 1'b0; e.ovf = 1'b0;
    end
    return e;
  endfunction

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got q=0x%0h r=0x%0h required no done", quotient_out, remainder_out);
      end else begin
        e = exp_q.pop_front();
        check("quotient", quotient_out, e.q);
        check("remainder", remainder_out, e.r);
        check("div_by_zero", div_by_zero, e.dbz);
        check("overflow", overflow, e.ovf);
      end
    end
  end

  task automatic wait_done(input string tag, output int lat, output int bcnt);
    lat  = 1;
    bcnt = int'(busy);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      bcnt += int'(busy);
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done after %0d edges required done", tag, lat);
    end
  endtask

  task automatic run_one(input int a, input int b, input string tag, output int lat, output int bcnt);
    @(negedge clk);
    dividend_in = W'(a);
    divisor_in  = W'(b);
    start       = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    start       = 1'b0;
    dividend_in = W'($urandom);
    divisor_in  = W'($urandom);
    wait_done(tag, lat, bcnt);
    if (done) check({tag, "_latency"}, lat, (b == 0) ? 1 : W + 2);
  endtask

  initial begin
    int lat;
    int bcnt;
    int a;
    int b;
    rst = 1'b1; start = 1'b0; dividend_in = '0; divisor_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_q", quotient_out, 0);
    check("reset_r", remainder_out, 0);

    run_one(100, 7, "t1", lat, bcnt);
    check("t1_busy_cycles", bcnt, 9);
    run_one(-100, 7, "t2a", lat, bcnt);
    run_one(100, -7, "t2b", lat, bcnt);
    run_one(-100, -7, "t2c", lat, bcnt);
    run_one(5, 0, "t3a", lat, bcnt);
    run_one(6, 3, "t3b", lat, bcnt);
    run_one(-128, -1, "t4a", lat, bcnt);
    run_one(-128, 1, "t4b", lat, bcnt);
    run_one(-128, 3, "t4c", lat, bcnt);
    run_one(0, 55, "zero_dividend", lat, bcnt);
    run_one(-3, 100, "small_dividend", lat, bcnt);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    dividend_in = W'(50); divisor_in = W'(6); start = 1'b1;
    exp_q.push_back(model(50, 6));
    @(negedge clk);
    wait_done("t5a", lat, bcnt);
    if (done) check("t5a_latency", lat, W + 2);
    dividend_in = W'(3); divisor_in = W'(5);
    exp_q.push_back(model(3, 5));
    @(negedge clk);
    start = 1'b0;
    wait_done("t5b", lat, bcnt);
    if (done) check("t5_gap", lat, W + 2);

    // Reset in the 4th ITER cycle aborts the operation.
    @(negedge clk);
    dividend_in = W'(77); divisor_in = W'(9); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_q", quotient_out, 0);
    check("abort_r", remainder_out, 0);
    check("abort_flags", {div_by_zero, overflow}, 0);

    // A start pulse while busy must be ignored.
    @(negedge clk);
    dividend_in = W'(3); divisor_in = W'(5); start = 1'b1;
    exp_q.push_back(model(3, 5));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dividend_in = W'(1); divisor_in = W'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6", lat, bcnt);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      a = sx(W'($urandom));
      case ($urandom_range(0, 15))
        0:       b = 0;
        1:       begin a = -(1 << (W-1)); b = -1; end
        default: b = sx(W'($urandom));
      endcase
      run_one(a, b, "rand", lat, bcnt);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
